// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-aware stream arbiter.
// Also provides a reference round-robin pick for reuse by other schedulers.
package stream_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 16;
  localparam int MAX_IDX = 4;

  // Next requester with req set, searching cyclically after last_idx.
  function automatic logic [MAX_IDX-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [MAX_IDX-1:0] last_idx,
    input int                 n
  );
    logic [MAX_IDX-1:0] r;
    logic               hit;
    int                 j;
    r   = '0;
    hit = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        j = (int'(last_idx) + k) % n;
        if (!hit && req[j]) begin
          hit = 1'b1;
          r   = MAX_IDX'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority.sv
// Combinational round-robin priority: rotate, find first one, unrotate.
// Search starts at last_idx+1 so the previous winner goes last.
module rr_priority
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int IDX_WIDTH = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    req,
  input  logic [IDX_WIDTH-1:0] last_idx,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [2*NUM_IN-1:0] dbl;
  logic [NUM_IN-1:0]   rot;
  int                  start;
  int                  off;

  // Rotate so the search start sits at bit 0, then take the lowest set bit.
  always_comb begin
    start = (int'(last_idx) + 1) % NUM_IN;
    dbl   = {req, req};
    rot   = NUM_IN'(dbl >> start);
    found = 1'b0;
    off   = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    idx = IDX_WIDTH'((start + off) % NUM_IN);
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter sharing one stream sink.
// Owner holds the sink until a last beat or the burst cap.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int IDX_WIDTH  = $clog2(NUM_IN),
  parameter int CNT_WIDTH  = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN-1:0]            in_last,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [NUM_IN-1:0]            grant,
  output logic [IDX_WIDTH-1:0]         grant_idx,
  output logic                         busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_RST =
    IDX_WIDTH'(NUM_IN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  arb_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic                 locked;
  logic                 beat;
  logic                 cap_hit;
  logic                 release_now;
  logic                 pick_found;
  logic [IDX_WIDTH-1:0] pick_idx;

  assign locked = (state_q == LOCKED);

  rr_priority #(
    .NUM_IN    (NUM_IN),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req      (in_valid),
    .last_idx (last_idx_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Output mux: pure wires from the owner, everything quiet in IDLE.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    in_ready  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = locked;
    if (locked) begin
      grant[grant_idx_q]    = 1'b1;
      grant_idx             = grant_idx_q;
      in_ready[grant_idx_q] = out_ready;
      out_valid             = in_valid[grant_idx_q];
      out_last              = in_last[grant_idx_q];
      out_data              =
        in_data[int'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Release on the source's last beat or when the burst cap is reached.
  always_comb begin
    beat        = out_valid & out_ready;
    cap_hit     = (MAX_BURST != 0) && (beat_cnt_q == CNT_MAX);
    release_now = out_last | cap_hit;
  end

  // Next-state: arbitrate in IDLE, count beats while LOCKED.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    beat_cnt_d  = beat_cnt_q;
    if (flush) begin
      state_d     = IDLE;
      grant_idx_d = '0;
      last_idx_d  = LAST_RST;
      beat_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_d     = LOCKED;
            grant_idx_d = pick_idx;
            beat_cnt_d  = '0;
          end
        end
        LOCKED: begin
          if (beat) begin
            if (release_now) begin
              state_d    = IDLE;
              last_idx_d = grant_idx_q;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State, owner, rotation pointer and beat counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      last_idx_q  <= LAST_RST;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter.
// Sources are beat queues; a packet-level model predicts every output.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready = 1'b0;
  logic [N-1:0]    grant;
  logic [1:0]      grant_idx;
  logic            busy;

  logic [8:0] q[N][$];

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;
  int vpct  = 100;
  int rmode = 0;
  int cyc   = 0;

  stream_rr_arbiter #(
    .NUM_IN     (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic push_pkt(input int src, input int len,
                          input int base);
    for (int k = 0; k < len; k++) begin
      logic [8:0] b;
      b = {(k == len - 1), 8'(base + k)};
      q[src].push_back(b);
    end
  endtask

  task automatic drive();
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0 && $urandom_range(1, 100) <= vpct) begin
        b = q[i][0];
        in_valid[i]         = 1'b1;
        in_data[i*DW +: DW] = b[7:0];
        in_last[i]          = b[8];
      end else begin
        in_valid[i]         = 1'b0;
        in_data[i*DW +: DW] = 8'($urandom);
        in_last[i]          = 1'($urandom);
      end
    end
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~cyc[0];
      default: out_ready = 1'($urandom);
    endcase
  endtask

  task automatic check();
    logic [8:0] b;
    if (m_owner < 0) begin
      chk("busy", 32'(busy), 0);
      chk("grant", 32'(grant), 0);
      chk("grant_idx", 32'(grant_idx), 0);
      chk("in_ready", 32'(in_ready), 0);
      chk("out_valid", 32'(out_valid), 0);
    end else begin
      chk("busy", 32'(busy), 1);
      chk("grant", 32'(grant), 32'(1 << m_owner));
      chk("grant_idx", 32'(grant_idx), 32'(m_owner));
      chk("in_ready", 32'(in_ready),
          out_ready ? 32'(1 << m_owner) : 0);
      chk("out_valid", 32'(out_valid), 32'(in_valid[m_owner]));
      chk("out_last", 32'(out_last), 32'(in_last[m_owner]));
      if (in_valid[m_owner]) begin
        b = q[m_owner][0];
        chk("out_data", 32'(out_data), 32'(b[7:0]));
      end
    end
  endtask

  task automatic update();
    bit hs;
    bit done;
    bit was_last;
    int j;
    hs = (m_owner >= 0) && in_valid[m_owner] && out_ready;
    was_last = (m_owner >= 0) ? in_last[m_owner] : 1'b0;
    if (hs) void'(q[m_owner].pop_front());
    if (flush) begin
      m_owner = -1;
      m_last  = N - 1;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      done = 0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!done && in_valid[j]) begin
          done    = 1;
          m_owner = j;
          m_cnt   = 0;
        end
      end
    end else if (hs) begin
      m_cnt++;
      if (was_last || (MB != 0 && m_cnt == MB)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive();
      @(negedge clk);
      check();
      @(posedge clk);
      update();
      cyc++;
      #1;
    end
  endtask

  task automatic flush_cycle();
    flush = 1'b1;
    run(1);
    flush = 1'b0;
  endtask

  initial begin
    // Reset state, with every input pushing to be accepted.
    in_valid  = '1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_grant_idx", 32'(grant_idx), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single 3-beat packet on requester 0.
    q[0].push_back(9'h0A1);
    q[0].push_back(9'h0A2);
    q[0].push_back(9'h1A3);
    run(5);
    chk("t1_drained", q[0].size(), 0);

    // Four requesters with 1-beat packets: one beat per 2 cycles.
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 4; p++)
        push_pkt(i, 1, i * 16 + p);
    run(32);
    for (int i = 0; i < N; i++)
      chk("t2_drained", q[i].size(), 0);

    // 40-beat packet on 2 with a cap of 16, requester 3 waiting.
    flush_cycle();
    push_pkt(2, 40, 0);
    push_pkt(3, 1, 8'h33);
    run(50);
    chk("t3_q2_drained", q[2].size(), 0);
    chk("t3_q3_drained", q[3].size(), 0);

    // out_ready toggling during a 5-beat packet, others pending.
    rmode = 1;
    flush_cycle();
    push_pkt(1, 5, 8'hB0);
    run(1);
    push_pkt(0, 1, 8'h70);
    push_pkt(3, 1, 8'h73);
    run(16);
    chk("t4_q1_drained", q[1].size(), 0);
    rmode = 0;
    run(8);

    // Flush during beat 2 of 4 with requesters 1 and 3 pending.
    flush_cycle();
    push_pkt(0, 4, 8'hC0);
    run(2);
    push_pkt(1, 1, 8'hD1);
    push_pkt(3, 1, 8'hD3);
    flush_cycle();
    q[0].delete();
    run(1);
    chk("t5_next_grant", 32'(grant_idx), 1);
    chk("t5_busy", 32'(busy), 1);
    run(6);

    // Randomised traffic with occasional flush.
    rmode = 2;
    vpct  = 75;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0)
          push_pkt(i, $urandom_range(1, 20), $urandom_range(0, 255));
      flush = ($urandom_range(0, 199) == 0);
      run(1);
    end
    flush = 1'b0;

    // Asynchronous reset mid-burst.
    rmode = 0;
    vpct  = 100;
    for (int i = 0; i < N; i++) q[i].delete();
    flush_cycle();
    push_pkt(0, 10, 8'hE0);
    push_pkt(1, 1, 8'hE1);
    push_pkt(2, 1, 8'hE2);
    run(4);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_grant_idx", 32'(grant_idx), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    q[0].delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    run(1);
    chk("arst_first_grant", 32'(grant_idx), 1);
    run(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
